// File: rtl/qnigma_mdio_master.sv
// Clause-22 MDIO master: turns one read/write request into a preamble + frame on
// mdc/mdo/mdt and shifts read data in from mdi.
module qnigma_mdio_master #(
  parameter int DIV     = 4,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        rnw,
  input  logic [4:0]  phy_adr,
  input  logic [4:0]  reg_adr,
  input  logic [15:0] wdat,
  output logic        rdy,
  output logic        rval,
  output logic [15:0] rdat,
  output logic        done,
  output logic        mdc,
  output logic        mdo,
  output logic        mdt,
  input  logic        mdi
);

  // state | meaning
  // IDLE  | waiting for req, mdc parked low, bus released
  // PRE   | PRE_LEN preamble ones
  // HDR   | ST, OP, PHYAD, REGAD (14 bits)
  // TA    | turnaround (2 bits), released on reads
  // DATA  | 16 data bits, driven on writes, sampled on reads
  // END   | one released idle bit, completion on its last cycle
  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, END} state_t;

  localparam logic [7:0] DIV_LD = 8'(DIV - 1);
  localparam logic [5:0] PRE_LD = 6'(PRE_LEN - 1);

  state_t      state, state_nx;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_ld;
  logic [31:0] tx;
  logic [15:0] rx;
  logic        rd;
  logic        eop;
  logic        last_bit;
  logic        pre_last;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    eop      = (state != IDLE) && mdc && (div_cnt == 8'd0);
    last_bit = eop && (bit_cnt == 6'd0);
    // one cycle ahead of the final END cycle, so done/rval/rdat register in step
    pre_last = (state == END) && mdc && (div_cnt == 8'd1);
    rdy      = (state == IDLE);
    state_nx = state;
    case (state)
      IDLE:    if (req)      state_nx = PRE;
      PRE:     if (last_bit) state_nx = HDR;
      HDR:     if (last_bit) state_nx = TA;
      TA:      if (last_bit) state_nx = DATA;
      DATA:    if (last_bit) state_nx = END;
      END:     if (last_bit) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
    bit_ld = 6'd0;
    case (state_nx)
      PRE:     bit_ld = PRE_LD;
      HDR:     bit_ld = 6'd13;
      TA:      bit_ld = 6'd1;
      DATA:    bit_ld = 6'd15;
      default: bit_ld = 6'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      mdc     <= 1'b0;
      mdo     <= 1'b1;
      mdt     <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      rd      <= 1'b0;
      rdat    <= '0;
      rval    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= pre_last;
      rval <= pre_last && rd;
      if (pre_last && rd) rdat <= rx;
      if ((state == DATA) && !mdc && (div_cnt == 8'd0)) rx <= {rx[14:0], mdi};

      if (state == IDLE) begin
        if (req) begin
          rd      <= rnw;
          // read frames carry ones in TA/DATA so mdo idles high while released
          tx      <= {2'b01, rnw ? 2'b10 : 2'b01, phy_adr, reg_adr,
                      rnw ? 2'b11 : 2'b10, rnw ? 16'hFFFF : wdat};
          bit_cnt <= PRE_LD;
          div_cnt <= DIV_LD;
          mdc     <= 1'b0;
          mdo     <= 1'b1;
          mdt     <= 1'b1;
        end
      end else if (eop) begin
        div_cnt <= DIV_LD;
        mdc     <= 1'b0;
        bit_cnt <= (state_nx == state) ? bit_cnt - 6'd1 : bit_ld;
        case (state_nx)
          PRE: begin
            mdo <= 1'b1;
            mdt <= 1'b1;
          end
          HDR, TA, DATA: begin
            mdo <= tx[31];
            tx  <= {tx[30:0], 1'b0};
            mdt <= (state_nx == HDR) || !rd;
          end
          default: begin
            mdo <= 1'b1;
            mdt <= 1'b0;
          end
        endcase
      end else if (div_cnt == 8'd0) begin
        mdc     <= ~mdc;
        div_cnt <= DIV_LD;
      end else begin
        div_cnt <= div_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_qnigma_mdio_master.sv
// Directed bench for qnigma_mdio_master: captures mdo/mdt at mdc rising edges,
// models a PHY register file on mdi, and checks framing, latency and reset.
module tb_qnigma_mdio_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, req2 = 1'b0;
  logic        rnw = 1'b0;
  logic [4:0]  phy_adr = '0, reg_adr = '0;
  logic [15:0] wdat = '0;
  logic        rdy, rval, done, mdc, mdo, mdt, mdi;
  logic [15:0] rdat;
  logic        rdy2, rval2, done2, mdc2, mdo2, mdt2;
  logic [15:0] rdat2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qnigma_mdio_master u_dut (
    .clk(clk), .rst(rst), .req(req), .rnw(rnw), .phy_adr(phy_adr), .reg_adr(reg_adr),
    .wdat(wdat), .rdy(rdy), .rval(rval), .rdat(rdat), .done(done),
    .mdc(mdc), .mdo(mdo), .mdt(mdt), .mdi(mdi));

  qnigma_mdio_master #(.DIV(2), .PRE_LEN(1)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .rnw(rnw), .phy_adr(phy_adr), .reg_adr(reg_adr),
    .wdat(wdat), .rdy(rdy2), .rval(rval2), .rdat(rdat2), .done(done2),
    .mdc(mdc2), .mdo(mdo2), .mdt(mdt2), .mdi(1'b1));

  // PHY model: register file, drives read data during periods 48..63
  logic [15:0] phy_regs [32];
  logic [1:0]  mdi_mode = 2'd0;
  logic [6:0]  nrise = '0;
  logic [6:0]  bidx;
  logic        mdi_phy;

  always_comb begin
    bidx    = 7'd63 - nrise;
    mdi_phy = 1'b1;
    if (nrise >= 7'd48 && nrise <= 7'd63) mdi_phy = phy_regs[reg_adr][bidx[3:0]];
  end
  assign mdi = (mdi_mode == 2'd0) ? mdi_phy : (mdi_mode == 2'd1);

  int          cyc = 0;
  int          t_acc = 0, t_done = 0, t_rdy = 0, done_cnt = 0, rval_cnt = 0;
  logic        mdc_q = 1'b0, rdy_q = 1'b0;
  logic [64:0] cap = '0, tcap = '0;
  logic [15:0] rdat_rv = '0;

  int          t_acc2 = 0, t_done2 = 0, done_cnt2 = 0, last_rise2 = 0, per2 = 0;
  logic [6:0]  nrise2 = '0;
  logic        mdc2_q = 1'b0;
  logic [33:0] cap2 = '0, tcap2 = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    mdc_q <= mdc;
    rdy_q <= rdy;
    if (req && rdy) begin
      t_acc <= cyc;
      nrise <= '0;
      cap   <= '0;
      tcap  <= '0;
    end else if (mdc && !mdc_q) begin
      nrise <= nrise + 7'd1;
      cap   <= {cap[63:0], mdo};
      tcap  <= {tcap[63:0], mdt};
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      t_done   <= cyc;
    end
    if (rval) begin
      rval_cnt <= rval_cnt + 1;
      rdat_rv  <= rdat;
    end
    if (rdy && !rdy_q) t_rdy <= cyc;

    mdc2_q <= mdc2;
    if (req2 && rdy2) begin
      t_acc2 <= cyc;
      nrise2 <= '0;
      cap2   <= '0;
      tcap2  <= '0;
    end else if (mdc2 && !mdc2_q) begin
      nrise2     <= nrise2 + 7'd1;
      cap2       <= {cap2[32:0], mdo2};
      tcap2      <= {tcap2[32:0], mdt2};
      last_rise2 <= cyc;
      per2       <= cyc - last_rise2;
    end
    if (done2) begin
      done_cnt2 <= done_cnt2 + 1;
      t_done2   <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic r, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] w);
    @(negedge clk);
    rnw = r; phy_adr = pa; reg_adr = ra; wdat = w; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int start;
    start = done_cnt;
    for (int i = 0; i < 2000 && done_cnt == start; i++) @(negedge clk);
    chk(tag, 128'(done_cnt != start), 128'd1);
  endtask

  task automatic run_read(input string tag, input logic [15:0] exp);
    int rv0;
    rv0 = rval_cnt;
    issue(1'b1, 5'd1, 5'd4, 16'h0000);
    wait_done({tag, "_tmo"});
    @(negedge clk);
    chk({tag, "_rdat"}, 128'(rdat_rv), 128'(exp));
    chk({tag, "_rvals"}, 128'(rval_cnt - rv0), 128'd1);
  endtask

  int d0, r0, ta1, rv_hold;

  initial begin
    for (int i = 0; i < 32; i++) phy_regs[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_outs", {rdy, rval, done, mdc, mdo, mdt, rdat}, {6'b100010, 16'h0000});
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: default write
    issue(1'b0, 5'd1, 5'd4, 16'hA5C3);
    wait_done("wr_tmo");
    @(negedge clk);
    chk("wr_frame", 128'(cap), 128'({32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd4, 2'b10, 16'hA5C3, 1'b1}));
    chk("wr_mdt", 128'(tcap), 128'({{64{1'b1}}, 1'b0}));
    chk("wr_bits", 128'(nrise), 128'd65);
    chk("wr_latency", 128'(t_done - t_acc), 128'd520);
    if (cap[30:29] == 2'b01) phy_regs[cap[23:19]] = cap[16:1];
    chk("emu_reg4", 128'(phy_regs[4]), 128'h0000_A5C3);
    chk("wr_rdat_kept", 128'(rdat), 128'h0);

    // 2: read back through the PHY model
    run_read("rd", 16'hA5C3);
    chk("rd_frame", 128'(cap), 128'({32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd4, 2'b11, 16'hFFFF, 1'b1}));
    chk("rd_mdt", 128'(tcap), 128'({{46{1'b1}}, {19{1'b0}}}));
    chk("rd_latency", 128'(t_done - t_acc), 128'd520);
    chk("rd_rdy_rise", 128'(t_rdy - t_acc), 128'd521);
    chk("rd_rdat_hold", 128'(rdat), 128'h0000_A5C3);

    // 3: mdi tied high / low
    mdi_mode = 2'd1;
    run_read("tie_hi", 16'hFFFF);
    mdi_mode = 2'd2;
    run_read("tie_lo", 16'h0000);
    mdi_mode = 2'd0;

    // 4: req held high across a frame, then back-to-back
    d0 = done_cnt;
    r0 = rval_cnt;
    @(negedge clk);
    rnw = 1'b1; phy_adr = 5'd1; reg_adr = 5'd4; req = 1'b1;
    @(negedge clk);
    ta1 = t_acc;
    wait_done("b2b_tmo1");
    chk("b2b_one_done", 128'(done_cnt - d0), 128'd1);
    @(negedge clk);
    req = 1'b0;
    chk("b2b_gap", 128'(t_acc - ta1), 128'd521);
    wait_done("b2b_tmo2");
    chk("b2b_latency2", 128'(t_done - t_acc), 128'd520);
    chk("b2b_dones", 128'(done_cnt - d0), 128'd2);
    chk("b2b_rvals", 128'(rval_cnt - r0), 128'd2);
    chk("b2b_rdat", 128'(rdat_rv), 128'h0000_A5C3);

    // 5: reset during bit 40 of a read
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    r0 = rval_cnt;
    issue(1'b1, 5'd1, 5'd4, 16'h0000);
    repeat (40 * 8 + 3) @(negedge clk);
    chk("rst_pre_mdt", 128'(mdt), 128'd1);
    rv_hold = 32'(rdat);
    chk("rst_pre_rdat", 128'(rv_hold), 128'h0000_A5C3);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_outs", {rdy, mdc, mdt, mdo, rdat}, {4'b1001, 16'h0000});
    repeat (700) @(negedge clk);
    chk("rst_no_done", 128'(done_cnt - d0), 128'd0);
    chk("rst_no_rval", 128'(rval_cnt - r0), 128'd0);
    chk("rst_idle", {rdy, mdc}, 2'b10);

    // 6: DIV=2, PRE_LEN=1 write
    @(negedge clk);
    rnw = 1'b0; phy_adr = 5'd3; reg_adr = 5'd7; wdat = 16'h1234; req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    d0 = done_cnt2;
    for (int i = 0; i < 500 && done_cnt2 == d0; i++) @(negedge clk);
    chk("s_tmo", 128'(done_cnt2 != d0), 128'd1);
    @(negedge clk);
    chk("s_frame", 128'(cap2), 128'({1'b1, 2'b01, 2'b01, 5'd3, 5'd7, 2'b10, 16'h1234, 1'b1}));
    chk("s_mdt", 128'(tcap2), 128'({{33{1'b1}}, 1'b0}));
    chk("s_bits", 128'(nrise2), 128'd34);
    chk("s_latency", 128'(t_done2 - t_acc2), 128'd136);
    chk("s_mdc_per", 128'(per2), 128'd4);
    chk("s_rdy", 128'(rdy2), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qnigma_mdio_master.md
Name: qnigma_mdio_master

Overview:
MDIO station-management master: converts single register read/write requests into IEEE 802.3 clause-22 frames on mdc/mdo/mdt, and samples mdi to return read data. Sits directly upstream of the PHY-side MDIO interface and drives its mdc/mdo/mdt inputs. Used in simulation against the MDIO PHY emulator and in silicon against a real PHY.

Parameters:
DIV, 4, mdc half-period in clk cycles (legal range 2..255)
PRE_LEN, 32, number of preamble '1' bits (1..32)

Ports:
clk      in   1   system clock
rst      in   1   reset, synchronous, active-low
req      in   1   request strobe, accepted only when rdy=1
rnw      in   1   1 = read, 0 = write; sampled with req
phy_adr  in   5   PHY address; sampled with req
reg_adr  in   5   register address; sampled with req
wdat     in   16  write data; sampled with req
rdy      out  1   idle, able to accept req
rval     out  1   1-cycle pulse: rdat valid (read completed)
rdat     out  16  read data; held until the next read completes
done     out  1   1-cycle pulse at the end of any frame (read or write)
mdc      out  1   management clock
mdo      out  1   serial data out
mdt      out  1   output enable: 1 = master drives mdio, 0 = released
mdi      in   1   serial data in from the PHY

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, rdy=1, rval=0, done=0, rdat=0, mdc=0, mdo=1, mdt=0. All divider and bit counters clear. Reset mid-frame aborts the frame immediately; no rval or done is issued for it.
- Accept: at a clk edge with req=1 and rdy=1, latch rnw/phy_adr/reg_adr/wdat and set rdy=0. A req while rdy=0 is ignored and not queued.
- Bit timing: each bit period is 2*DIV clk cycles. mdc=0 for the first DIV cycles and 1 for the second DIV cycles. mdo/mdt update on the clk cycle where mdc goes 1->0 (the start of the period; the first period starts the cycle after accept). mdi is sampled on the clk cycle where mdc goes 0->1.
- Frame, MSB first: PRE (PRE_LEN x '1', mdt=1) -> ST '01' -> OP (read '10', write '01') -> PHYAD[4:0] -> REGAD[4:0] -> TA -> DATA[15:0].
- TA: write drives '10' with mdt=1. Read sets mdt=0 for both TA bits, with mdo=1.
- DATA: write drives wdat[15:0] with mdt=1. Read keeps mdt=0 and shifts in 16 sampled mdi bits, MSB first.
- Frame states: IDLE, PRE, HDR (14 bits: ST+OP+PHYAD+REGAD), TA (2), DATA (16), END.
- END: one full bit period with mdt=0, mdo=1, mdc toggling. This is the idle bit.
- Completion: on the last clk cycle of the END period:
  - done=1 for one cycle;
  - for a read, rdat is loaded and rval=1 in the same cycle;
  - rdy returns to 1 in the following cycle.
- Latency, accept at cycle T: frame bit count N = PRE_LEN+32+1. done is asserted at T + N*2*DIV. Defaults: N=65, done at T+520.
- mdc runs only between accept and done; mdc=0 in IDLE.
- Write never alters rdat.
- Back-to-back: a req in the cycle rdy rises is accepted. The new frame's first period begins on the next cycle.
- Counters: divider counter 8 bits; bit counter 6 bits, no wrap within a frame.

Test Plan:
1. Write phy_adr=1, reg_adr=0x04, wdat=0xA5C3, defaults -> 32 ones, then 0101 00001 00100 10 1010010111000011 on mdo at mdc rising edges; mdt=1 for 64 bits then 0; done at T+520; emulator register 4 = 0xA5C3.
2. Read phy_adr=1, reg_adr=0x04 after test 1 -> mdt=0 from TA onward; rval pulse with rdat=0xA5C3 coincident with done at T+520; rdy=1 at T+521.
3. Read with mdi tied high (no PHY) -> rdat=0xFFFF, rval pulses once; tied low -> rdat=0x0000.
4. req pulsed every cycle during a frame -> only the first accepted; exactly one done per frame; an immediate req on rdy rise starts the next frame with no gap beyond the END bit.
5. rst=0 for one cycle during bit 40 of a read -> next cycle mdc=0, mdt=0, mdo=1, rdy=1; no rval/done; previous rdat replaced by 0.
6. DIV=2, PRE_LEN=1, write -> mdc period 4 clk cycles, frame N=34, done at T+136.
